// File: rtl/dmem_access_ctrl_if.sv
// Data-memory req/ack port between the access controller (master) and memory (slave).
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: IDLE->BUSY->DONE per access, pipeline stall, ack timeout.
// Optional perf counters enabled by defining DMEM_PERF_CNT_EN.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    dmem_access_ctrl_if.master dmem,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic [31:0]       access_cnt_o,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [TO_W-1:0]   cnt_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              valid_q;
    logic              err_q;
    logic              acc;

    assign acc = start_i & (MemRead_i | MemWrite_i);

    // Stall is combinational in IDLE so EX/MEM holds on the request cycle;
    // gated by reset so it drops asynchronously with the state.
    assign stall_o = rst_i & (((state_q == IDLE) & acc) | (state_q == BUSY));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (acc) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        we_q    <= MemWrite_i;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem.ack) begin
                        rdata_q <= we_q ? '0 : dmem.rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem.req      = req_q;
    assign dmem.we       = we_q;
    assign dmem.addr     = addr_q;
    assign dmem.wdata    = wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = valid_q;
    assign err_o         = err_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] acc_cnt_q, acc_cnt_d;
    logic [31:0] stl_cnt_q, stl_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        stl_cnt_d = stl_cnt_q;
        if ((state_q == DONE) && (acc_cnt_q != 32'hFFFF_FFFF))
            acc_cnt_d = acc_cnt_q + 32'd1;
        if (stall_o && (stl_cnt_q != 32'hFFFF_FFFF))
            stl_cnt_d = stl_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_cnt_q <= '0;
            stl_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
            stl_cnt_q <= stl_cnt_d;
        end
    end

    assign access_cnt_o = acc_cnt_q;
    assign stall_cnt_o  = stl_cnt_q;
`else
    assign access_cnt_o = 32'd0;
    assign stall_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: loads, stores, timeout, priority, reset, counters.
module tb_dmem_access_ctrl;

`ifdef DMEM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mrd = 1'b0;
    logic        mwr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ack = 1'b0;
    logic [31:0] rdat = '0;
    logic        stall;
    logic [31:0] rdata_o;
    logic        valid;
    logic        err;
    logic [31:0] acnt;
    logic [31:0] scnt;

    int checks = 0;
    int failures = 0;

    int          stl, busy, vld;
    logic [31:0] rdo, a_s, wd_s;
    logic        we_s, stable;

    dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    assign mem_if.ack   = ack;
    assign mem_if.rdata = rdat;

    dmem_access_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .TO_W(5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .start_i      (start),
        .MemRead_i    (mrd),
        .MemWrite_i   (mwr),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .dmem         (mem_if.master),
        .stall_o      (stall),
        .rdata_o      (rdata_o),
        .rdata_valid_o(valid),
        .err_o        (err),
        .access_cnt_o (acnt),
        .stall_cnt_o  (scnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access; memory acks on the k-th req cycle (k=0: never acks).
    task automatic run_access(
        input logic rd, input logic wr,
        input logic [31:0] a, input logic [31:0] wd,
        input int k, input logic [31:0] rdm
    );
        bit done;
        done = 1'b0;
        stl = 0; busy = 0; vld = 0;
        rdo = '0; a_s = '0; wd_s = '0; we_s = 1'b0; stable = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #2;
            ack = 1'b0;
            rdat = '0;
            if (c == 0) begin
                start = 1'b1; mrd = rd; mwr = wr; addr = a; wdata = wd;
            end
            #1;
            if (stall) stl++;
            if (mem_if.req) begin
                busy++;
                if (busy == 1) begin
                    we_s = mem_if.we; a_s = mem_if.addr; wd_s = mem_if.wdata;
                end else if (mem_if.we !== we_s || mem_if.addr !== a_s ||
                             mem_if.wdata !== wd_s) begin
                    stable = 1'b0;
                end
                if (k > 0 && busy == k) begin
                    ack = 1'b1; rdat = rdm;
                end
            end
            if (valid) begin
                vld++; rdo = rdata_o; mrd = 1'b0; mwr = 1'b0;
            end else if (vld > 0) begin
                done = 1'b1;
                break;
            end
        end
        mrd = 1'b0; mwr = 1'b0; ack = 1'b0;
        chk("access_completes_in_bound", 32'(done), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", 32'(mem_if.req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_acnt", acnt, 32'd0);
        rst_n = 1'b1;

        // Load, ack on the 3rd BUSY cycle
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        chk("t1_stall", 32'(stl), 32'd4);
        chk("t1_busy", 32'(busy), 32'd3);
        chk("t1_rdata", rdo, 32'hDEADBEEF);
        chk("t1_valid_len", 32'(vld), 32'd1);
        chk("t1_we", 32'(we_s), 32'd0);
        chk("t1_addr", a_s, 32'h100);
        chk("t1_stable", 32'(stable), 32'd1);

        // Store, ack on first BUSY cycle
        run_access(1'b0, 1'b1, 32'h40, 32'h1234, 1, 32'hFFFFFFFF);
        chk("t2_we", 32'(we_s), 32'd1);
        chk("t2_addr", a_s, 32'h40);
        chk("t2_wdata", wd_s, 32'h1234);
        chk("t2_stall", 32'(stl), 32'd2);
        chk("t2_rdata", rdo, 32'd0);
        chk("t2_valid_len", 32'(vld), 32'd1);

        // Timeout: no ack
        run_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h0);
        chk("t3_busy", 32'(busy), 32'd16);
        chk("t3_stall", 32'(stl), 32'd17);
        chk("t3_valid_len", 32'(vld), 32'd1);
        chk("t3_rdata", rdo, 32'd0);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_stable", 32'(stable), 32'd1);
        run_access(1'b1, 1'b0, 32'h204, 32'h0, 1, 32'hA5A5A5A5);
        chk("t3_good_rdata", rdo, 32'hA5A5A5A5);
        chk("t3_err_sticky", 32'(err), 32'd1);

        // Read and write both set: write wins
        run_access(1'b1, 1'b1, 32'h80, 32'h55, 2, 32'h77);
        chk("t4_we", 32'(we_s), 32'd1);
        chk("t4_wdata", wd_s, 32'h55);
        chk("t4_rdata", rdo, 32'd0);

        // start_i low: no access
        @(posedge clk); #2;
        start = 1'b0; mrd = 1'b1; addr = 32'h300;
        #1;
        chk("t4_nostart_stall", 32'(stall), 32'd0);
        @(posedge clk); #2;
        chk("t4_nostart_req", 32'(mem_if.req), 32'd0);
        chk("t4_nostart_stall2", 32'(stall), 32'd0);
        mrd = 1'b0;

        // Reset asserted during BUSY
        @(posedge clk); #2;
        start = 1'b1; mrd = 1'b1; addr = 32'h400;
        @(posedge clk); #2;
        chk("t5_busy_req", 32'(mem_if.req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req", 32'(mem_if.req), 32'd0);
        chk("t5_rst_stall", 32'(stall), 32'd0);
        chk("t5_rst_err", 32'(err), 32'd0);
        mrd = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_access(1'b1, 1'b0, 32'h404, 32'h0, 2, 32'h0BADF00D);
        chk("t5_after_rdata", rdo, 32'h0BADF00D);
        chk("t5_after_stall", 32'(stl), 32'd3);
        chk("t5_after_err", 32'(err), 32'd0);

        // Perf counters from a fresh reset: three loads, ack delay 2
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 2, 32'h1);
        run_access(1'b1, 1'b0, 32'h14, 32'h0, 2, 32'h2);
        run_access(1'b1, 1'b0, 32'h18, 32'h0, 2, 32'h3);
        chk("t6_last_rdata", rdo, 32'h3);
        chk("t6_acnt", acnt, PERF ? 32'd3 : 32'd0);
        chk("t6_scnt", scnt, PERF ? 32'd9 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
